frc_timer_intr: RTL



---
 rtl/frc_timer_intr_pkg.sv | 15 +
 rtl/frc_timer_intr_irq_sync.sv | 29 ++
 rtl/frc_timer_intr.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/frc_timer_intr_pkg.sv
// frc_timer_intr shared constants: timer window map, privilege, reset values.
// Optional prescaler is enabled with `define TIMER_PRESCALER_EN.
package frc_timer_intr_pkg;

    localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
    localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
    localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TMR_CTRL        = 3'd4;
    localparam logic [2:0] TMR_EXTSTAT     = 3'd5;

    localparam logic [1:0]  M_MODE       = 2'b11;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/frc_timer_intr_irq_sync.sv
// irq_sync: two-flop synchronizer for an async line plus a rising-edge
// one-shot (combinational from the synchronized and delayed samples).
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    // synchronize the line and keep one older sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/frc_timer_intr.sv
// frc_timer_intr: 64-bit mtime/mtimecmp, external irq pending, take request.
// Build with `define TIMER_PRESCALER_EN to get the CTRL[15:8] prescaler.
module frc_timer_intr
    import frc_timer_intr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  tmr_adr,
    input  logic        tmr_we,
    input  logic [31:0] tmr_wdata,
    input  logic        tmr_re,
    output logic [31:0] tmr_rdata,
    input  logic        ext_irq_in,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        csr_rmie,
    input  logic        cpu_stat_pc,
    output logic        g_interrupt,
    output logic        frc_cntr_val_leq,
    output logic        interrupts_in_pc_state,
    output logic [1:0]  g_interrupt_priv
);

    logic [31:0] mtime_lo;
    logic [31:0] mtime_hi;
    logic [31:0] cmp_lo;
    logic [31:0] cmp_hi;
    logic [63:0] mtime_inc;
    logic        cnt_en;
    logic [7:0]  prescale;
    logic        tick;
    logic        pending;
    logic        issued;
    logic        leq;
    logic        ext_rise;
    logic        req;
    logic        take;

    logic wr_lo;
    logic wr_hi;
    logic wr_clo;
    logic wr_chi;
    logic wr_ctrl;
    logic wr_ext;

    assign wr_lo   = tmr_we & (tmr_adr == TMR_MTIME_LO);
    assign wr_hi   = tmr_we & (tmr_adr == TMR_MTIME_HI);
    assign wr_clo  = tmr_we & (tmr_adr == TMR_MTIMECMP_LO);
    assign wr_chi  = tmr_we & (tmr_adr == TMR_MTIMECMP_HI);
    assign wr_ctrl = tmr_we & (tmr_adr == TMR_CTRL);
    assign wr_ext  = tmr_we & (tmr_adr == TMR_EXTSTAT);

    assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] pre_cnt;

    assign tick = cnt_en & (pre_cnt == prescale);

    // prescale counter: 0..prescale while enabled, cleared by CTRL writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= 8'd0;
        else if (wr_ctrl)
            pre_cnt <= 8'd0;
        else if (cnt_en)
            pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
    end

    // prescale field of CTRL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prescale <= 8'd0;
        else if (wr_ctrl)
            prescale <= tmr_wdata[15:8];
    end
`else
    assign tick     = cnt_en;
    assign prescale = 8'd0;
`endif

    // count enable bit of CTRL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_en <= 1'b0;
        else if (wr_ctrl)
            cnt_en <= tmr_wdata[0];
    end

    // mtime: a bus write to either half beats the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_lo <= 32'd0;
            mtime_hi <= 32'd0;
        end else if (wr_lo) begin
            mtime_lo <= tmr_wdata;
        end else if (wr_hi) begin
            mtime_hi <= tmr_wdata;
        end else if (tick) begin
            mtime_lo <= mtime_inc[31:0];
            mtime_hi <= mtime_inc[63:32];
        end
    end

    // mtimecmp halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_lo <= MTIMECMP_RST[31:0];
            cmp_hi <= MTIMECMP_RST[63:32];
        end else begin
            if (wr_clo)
                cmp_lo <= tmr_wdata;
            if (wr_chi)
                cmp_hi <= tmr_wdata;
        end
    end

    // registered compare on current register values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            leq <= 1'b0;
        else
            leq <= ({cmp_hi, cmp_lo} <= {mtime_hi, mtime_lo});
    end

    irq_sync u_ext_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_irq_in),
        .rise     (ext_rise)
    );

    // pending: edge sets, write-1 clears, set wins on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (ext_rise)
            pending <= 1'b1;
        else if (wr_ext && tmr_wdata[0])
            pending <= 1'b0;
    end

    assign req  = (csr_meie & pending) | (csr_mtie & leq);
    assign take = cpu_stat_pc & csr_rmie & req & ~issued;

    // issued blocks re-firing until MIE drops (handler entry/exit)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issued <= 1'b0;
        else if (!csr_rmie)
            issued <= 1'b0;
        else if (take)
            issued <= 1'b1;
    end

    // read port: captured on the strobe, held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_rdata <= 32'd0;
        end else if (tmr_re) begin
            case (tmr_adr)
                TMR_MTIME_LO:    tmr_rdata <= mtime_lo;
                TMR_MTIME_HI:    tmr_rdata <= mtime_hi;
                TMR_MTIMECMP_LO: tmr_rdata <= cmp_lo;
                TMR_MTIMECMP_HI: tmr_rdata <= cmp_hi;
                TMR_CTRL:        tmr_rdata <= {16'd0, prescale, 7'd0, cnt_en};
                TMR_EXTSTAT:     tmr_rdata <= {31'd0, pending};
                default:         tmr_rdata <= 32'd0;
            endcase
        end
    end

    assign g_interrupt            = pending;
    assign frc_cntr_val_leq       = leq;
    assign interrupts_in_pc_state = take;
    assign g_interrupt_priv       = M_MODE;

endmodule
